// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, fetch FSM
// states and PC helpers.
package if_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int INST_BYTES = 4;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  // Force an address onto an instruction boundary; low bits of a redirect
  // target are ignored.
  function automatic logic [ADDR_WIDTH-1:0] inst_align(input logic [ADDR_WIDTH-1:0] pc);
    return pc & ~(ADDR_WIDTH'(INST_BYTES - 1));
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Request/response bundle between the fetch stage (master) and the
// instruction cache (slave).
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (
    output req_addr,
    output req_valid,
    input  resp_data,
    input  resp_valid,
    input  resp_ready
  );

  modport slave (
    input  req_addr,
    input  req_valid,
    output resp_data,
    output resp_valid,
    output resp_ready
  );

endinterface

// File: rtl/if_fetch_inst_fifo.sv
// Instruction buffer between fetch and decode. Head entry is presented from
// registers; a flush empties the buffer and wins over push and pop.
module if_fetch_inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic             push_en;
  logic             pop_en;
  logic [CW-1:0]    count_after_pop;

  // Qualify push/pop; flush suppresses both so nothing is consumed.
  always_comb begin
    pop_en          = pop && (count != '0) && !flush;
    push_en         = push && ((count != DEPTH_C) || pop_en) && !flush;
    count_after_pop = count - CW'(pop_en);
    rd_ptr_next     = rd_ptr + PW'(pop_en);
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head view toward decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push_en);
      rd_ptr     <= rd_ptr_next;
      count      <= count_after_pop + CW'(push_en);
      head_valid <= (count_after_pop != '0) || push_en;
      // Surviving older entries stay ahead of the incoming one.
      if (count_after_pop != '0) begin
        head_data <= mem[rd_ptr_next];
      end else if (push_en) begin
        head_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one cache request at a time,
// buffers returned instructions with their PCs and handles redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    IBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_fetch_if.master            icache_if,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int                    CW      = $clog2(IBUF_DEPTH + 1);
  localparam logic [CW-1:0]         DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  run;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  req_fire;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [CW-1:0]         fifo_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;

  // Issue only from idle, with a free buffer slot reserved for the response.
  always_comb begin
    redirect_target = inst_align(redirect_pc);
    req_fire  = run && (state == F_IDLE) && icache_if.resp_ready &&
                (fifo_count < DEPTH_C) && !redirect_valid;
    fifo_push = (state == F_WAIT) && icache_if.resp_valid && !redirect_valid;
    fifo_pop  = inst_valid && inst_ready;
  end

  assign icache_if.req_valid = req_fire;
  assign icache_if.req_addr  = fetch_pc;

  // Fetch FSM, PC update and the post-reset run flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= F_IDLE;
      fetch_pc <= RESET_PC;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        F_IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end else if (req_fire) begin
            state <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (icache_if.resp_valid) begin
            state    <= F_IDLE;
            fetch_pc <= redirect_valid ? redirect_target : fetch_pc + PC_STEP;
          end else if (redirect_valid) begin
            state    <= F_DROP;
            fetch_pc <= redirect_target;
          end
        end
        F_DROP: begin
          // The outstanding response belongs to a dead path.
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end
          if (icache_if.resp_valid) begin
            state <= F_IDLE;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

  if_fetch_inst_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (IBUF_DEPTH)
  ) u_inst_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  ({fetch_pc, icache_if.resp_data}),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head_valid (inst_valid),
    .head_data  (fifo_head)
  );

  assign inst_pc   = fifo_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign inst_data = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cache model, reference PC/FIFO model and scenario tasks.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  if_fetch_if cache_bus ();

  if_fetch #(.RESET_PC(RST_PC), .IBUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_if      (cache_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;
  logic [31:0] out_pc;
  logic [31:0] last_issue_pc;
  bit          m_run, m_out, m_drop;
  int          cd, lat, n_issue, n_pop;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    exp_pc = RST_PC;
    m_run = 0; m_out = 0; m_drop = 0; cd = 0;
    cache_bus.resp_valid = 1'b0;
    cache_bus.resp_data  = '0;
    cache_bus.resp_ready = 1'b1;
  endtask

  // One clock: compare against the model before the edge, advance the
  // model, then drive the cache response for the following cycle.
  task automatic step();
    logic exp_req;
    int   cnt;
    #1;
    cnt = sb_q.size();
    exp_req = m_run && !m_out && cache_bus.resp_ready && (cnt < DEPTH) && !redirect_valid;
    n_tests++;
    if (cache_bus.req_valid !== exp_req) begin
      n_fail++;
      $display("FAIL req_valid @%0t: got %b expected %b", $time, cache_bus.req_valid, exp_req);
    end
    if (exp_req) begin
      n_tests++;
      if (cache_bus.req_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL req_addr @%0t: got %h expected %h", $time, cache_bus.req_addr, exp_pc);
      end
    end
    n_tests++;
    if (inst_valid !== (cnt != 0)) begin
      n_fail++;
      $display("FAIL inst_valid @%0t: got %b expected %b", $time, inst_valid, cnt != 0);
    end
    if (cnt != 0) begin
      n_tests++;
      if ({inst_pc, inst_data} !== sb_q[0]) begin
        n_fail++;
        $display("FAIL inst_head @%0t: got pc %h data %h expected pc %h data %h",
                 $time, inst_pc, inst_data, sb_q[0][63:32], sb_q[0][31:0]);
      end
    end
    if (inst_ready && cnt != 0 && !redirect_valid) begin
      sb_q.delete(0);
      n_pop++;
    end
    if (cache_bus.resp_valid) begin
      if (!m_drop && !redirect_valid) begin
        sb_q.push_back({exp_pc, inst_of(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      m_out = 0;
      m_drop = 0;
    end else if (redirect_valid && m_out) begin
      m_drop = 1;
    end
    if (redirect_valid) begin
      sb_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    if (exp_req) begin
      m_out = 1;
      cd = lat;
      out_pc = exp_pc;
      last_issue_pc = exp_pc;
      n_issue++;
    end
    m_run = 1;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    if (m_out) cd--;
    cache_bus.resp_valid = m_out && (cd <= 0);
    cache_bus.resp_data  = m_out ? inst_of(out_pc) : 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (cache_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s req_valid: got %b expected 0", tag, cache_bus.req_valid);
    end
    n_tests++;
    if (cache_bus.req_addr !== RST_PC) begin
      n_fail++; $display("FAIL %s req_addr: got %h expected %h", tag, cache_bus.req_addr, RST_PC);
    end
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s inst_valid: got %b expected 0", tag, inst_valid);
    end
    n_tests++;
    if (inst_data !== 32'h0) begin
      n_fail++; $display("FAIL %s inst_data: got %h expected 0", tag, inst_data);
    end
    n_tests++;
    if (inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL %s inst_pc: got %h expected 0", tag, inst_pc);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout expected event", tag);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hit_stream();
    int s_issue, s_pop;
    lat = 1; inst_ready = 1'b1;
    s_issue = n_issue; s_pop = n_pop;
    repeat (10) step();
    n_tests++;
    if (n_issue - s_issue != 5) begin
      n_fail++; $display("FAIL hit_issue_count: got %0d expected 5", n_issue - s_issue);
    end
    n_tests++;
    if (n_pop - s_pop != 4) begin
      n_fail++; $display("FAIL hit_pop_count: got %0d expected 4", n_pop - s_pop);
    end
  endtask

  task automatic test_backpressure();
    int s_issue, s_pop, i;
    cache_bus.resp_ready = 1'b0;
    for (i = 0; i < 30; i++) begin
      if (!m_out && sb_q.size() == 0) break;
      step();
    end
    if (i == 30) bound_fail("bp_drain");
    inst_ready = 1'b0;
    cache_bus.resp_ready = 1'b1;
    s_issue = n_issue; s_pop = n_pop;
    repeat (16) step();
    n_tests++;
    if (n_issue - s_issue != DEPTH) begin
      n_fail++; $display("FAIL bp_issue_count: got %0d expected %0d", n_issue - s_issue, DEPTH);
    end
    #1;
    n_tests++;
    if (cache_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_blocked: got %b expected 0", cache_bus.req_valid);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (4) step();
    n_tests++;
    if (n_issue - s_issue != DEPTH + 1 || n_pop - s_pop != 1) begin
      n_fail++; $display("FAIL bp_one_pop_one_req: got issues %0d pops %0d expected %0d and 1",
                         n_issue - s_issue, n_pop - s_pop, DEPTH + 1);
    end
  endtask

  task automatic test_redirect_miss();
    int i;
    bit saw_old;
    inst_ready = 1'b1;
    lat = 9;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    for (i = 0; i < 30; i++) begin
      if (m_out && !m_drop && out_pc == 32'h10) break;
      step();
    end
    if (i == 30) bound_fail("miss_issue_0x10");
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    lat = 1;
    saw_old = 0;
    step();
    for (i = 0; i < 30; i++) begin
      #1;
      if (inst_valid && inst_pc == 32'h10) saw_old = 1;
      if (cache_bus.req_valid) break;
      step();
    end
    if (i == 30) bound_fail("miss_next_req");
    n_tests++;
    if (cache_bus.req_addr !== 32'h200) begin
      n_fail++; $display("FAIL miss_next_addr: got %h expected 00000200", cache_bus.req_addr);
    end
    for (i = 0; i < 12; i++) begin
      #1;
      if (inst_valid && inst_pc == 32'h10) saw_old = 1;
      step();
    end
    n_tests++;
    if (saw_old) begin
      n_fail++; $display("FAIL miss_dropped_pc: got pc 00000010 on decode expected never");
    end
  endtask

  task automatic test_same_cycle_redirect();
    int i;
    inst_ready = 1'b1;
    lat = 3;
    for (i = 0; i < 30; i++) begin
      if (cache_bus.resp_valid && !m_drop) break;
      step();
    end
    if (i == 30) bound_fail("same_cycle_resp");
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_inst_valid: got %b expected 0", inst_valid);
    end
    n_tests++;
    if (cache_bus.req_valid !== 1'b1 || cache_bus.req_addr !== 32'h40) begin
      n_fail++; $display("FAIL same_cycle_next_req: got %b/%h expected 1/00000040",
                         cache_bus.req_valid, cache_bus.req_addr);
    end
  endtask

  task automatic test_flush_pop();
    int i;
    lat = 1;
    inst_ready = 1'b0;
    for (i = 0; i < 30; i++) begin
      if (sb_q.size() == 3) break;
      step();
    end
    if (i == 30) bound_fail("flush_fill");
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_vs_pop: got inst_valid %b expected 0", inst_valid);
    end
    repeat (3) step();
  endtask

  task automatic test_wrap();
    int i;
    inst_ready = 1'b1;
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    for (i = 0; i < 30; i++) begin
      #1;
      if (cache_bus.req_valid && cache_bus.req_addr == 32'hFFFF_FFFC) break;
      step();
    end
    if (i == 30) bound_fail("wrap_first_req");
    step();
    for (i = 0; i < 30; i++) begin
      #1;
      if (cache_bus.req_valid) break;
      step();
    end
    if (i == 30) bound_fail("wrap_second_req");
    n_tests++;
    if (cache_bus.req_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", cache_bus.req_addr);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid_miss();
    int i;
    inst_ready = 1'b0;
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    for (i = 0; i < 30; i++) begin
      if (sb_q.size() == 2) break;
      step();
    end
    if (i == 30) bound_fail("midmiss_fill");
    lat = 20;
    for (i = 0; i < 30; i++) begin
      if (m_out && cd >= 15) break;
      step();
    end
    if (i == 30) bound_fail("midmiss_issue");
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midmiss_reset");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    repeat (6) step();
  endtask

  initial begin
    n_issue = 0; n_pop = 0; lat = 1;
    model_reset();
    test_reset();
    test_hit_stream();
    test_backpressure();
    test_redirect_miss();
    test_same_cycle_redirect();
    test_flush_pop();
    test_wrap();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
